// File: rtl/axi_mem_if_pkg.sv
// Shared types for the AXI memory interface: SRAM port ownership and
// elaboration helpers.
`timescale 1ns/1ps
package axi_mem_if_pkg;

  typedef enum logic {
    OWN_RD = 1'b0,
    OWN_WR = 1'b1
  } owner_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_mem_wrr_core.sv
// Two-input weighted round-robin for the shared SRAM port.
// state  | meaning
// OWN_RD | read side wins contested cycles until RD_WEIGHT consecutive wins
// OWN_WR | write side wins contested cycles until WR_WEIGHT consecutive wins
`timescale 1ns/1ps
module axi_mem_wrr_core
  import axi_mem_if_pkg::*;
#(
  parameter int WR_WEIGHT = 4,
  parameter int RD_WEIGHT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wr_valid_i,
  input  logic rd_valid_i,
  output logic wr_grant_o,
  output logic rd_grant_o
);

  localparam int CNT_W = $clog2(max_int(WR_WEIGHT, RD_WEIGHT)) + 1;

  if (WR_WEIGHT < 1 || RD_WEIGHT < 1) begin : g_bad_weight
    $fatal(1, "axi_mem_wrr_core: WR_WEIGHT and RD_WEIGHT must both be >= 1");
  end

  owner_t             owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_inc;
  logic [CNT_W-1:0]   weight;
  logic               contested;

  always_comb begin
    contested  = wr_valid_i & rd_valid_i;
    weight     = (owner_q == OWN_WR) ? CNT_W'(WR_WEIGHT) : CNT_W'(RD_WEIGHT);
    cnt_inc    = cnt_q + CNT_W'(1);
    wr_grant_o = wr_valid_i & (~rd_valid_i | (owner_q == OWN_WR));
    rd_grant_o = rd_valid_i & (~wr_valid_i | (owner_q == OWN_RD));
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    // Only contested cycles spend the owner's weight.
    if (contested) begin
      if (cnt_inc == weight) begin
        owner_d = (owner_q == OWN_WR) ? OWN_RD : OWN_WR;
        cnt_d   = '0;
      end else begin
        cnt_d   = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_RD;
      cnt_q   <= '0;
    end else begin
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/axi_mem_port_arbiter.sv
// Shares one single-port SRAM between the AXI write and read controllers,
// with weighted round-robin on contested cycles and a registered read valid.
`timescale 1ns/1ps
module axi_mem_port_arbiter
  import axi_mem_if_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 13,
  parameter int DATA_WIDTH     = 64,
  parameter int NUMBYTES       = DATA_WIDTH / 8,
  parameter int WR_WEIGHT      = 4,
  parameter int RD_WEIGHT      = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_valid_i,
  output logic                      wr_grant_o,
  input  logic                      wr_cen_i,
  input  logic                      wr_wen_i,
  input  logic [MEM_ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0]     wr_wdata_i,
  input  logic [NUMBYTES-1:0]       wr_be_i,
  input  logic                      rd_valid_i,
  output logic                      rd_grant_o,
  input  logic                      rd_cen_i,
  input  logic                      rd_wen_i,
  input  logic [MEM_ADDR_WIDTH-1:0] rd_addr_i,
  input  logic [DATA_WIDTH-1:0]     rd_wdata_i,
  input  logic [NUMBYTES-1:0]       rd_be_i,
  output logic                      rd_rvalid_o,
  output logic [DATA_WIDTH-1:0]     rd_rdata_o,
  output logic                      MEM_CEN_o,
  output logic                      MEM_WEN_o,
  output logic [MEM_ADDR_WIDTH-1:0] MEM_A_o,
  output logic [DATA_WIDTH-1:0]     MEM_D_o,
  output logic [NUMBYTES-1:0]       MEM_BE_o,
  input  logic [DATA_WIDTH-1:0]     MEM_Q_i
);

  logic rd_rvalid_q, rd_rvalid_d;

  axi_mem_wrr_core #(
    .WR_WEIGHT (WR_WEIGHT),
    .RD_WEIGHT (RD_WEIGHT)
  ) u_wrr_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid_i (wr_valid_i),
    .rd_valid_i (rd_valid_i),
    .wr_grant_o (wr_grant_o),
    .rd_grant_o (rd_grant_o)
  );

  // Idle cycles park the address/data lines on the read side so they never float.
  always_comb begin
    MEM_CEN_o = 1'b1;
    MEM_WEN_o = 1'b1;
    MEM_A_o   = rd_addr_i;
    MEM_D_o   = rd_wdata_i;
    MEM_BE_o  = rd_be_i;
    if (wr_grant_o) begin
      MEM_CEN_o = wr_cen_i;
      MEM_WEN_o = wr_wen_i;
      MEM_A_o   = wr_addr_i;
      MEM_D_o   = wr_wdata_i;
      MEM_BE_o  = wr_be_i;
    end else if (rd_grant_o) begin
      MEM_CEN_o = rd_cen_i;
      MEM_WEN_o = rd_wen_i;
    end
    rd_rvalid_d = rd_grant_o & ~rd_cen_i & rd_wen_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_rvalid_q <= 1'b0;
    end else begin
      rd_rvalid_q <= rd_rvalid_d;
    end
  end

  assign rd_rvalid_o = rd_rvalid_q;
  assign rd_rdata_o  = MEM_Q_i;

endmodule

// File: tb/tb_axi_mem_port_arbiter.sv
// Scoreboard bench: two arbiters (weights 4/4 and RD1/WR3) share stimulus;
// a reference model predicts grants, mux outputs and read returns.
`timescale 1ns/1ps
module tb_axi_mem_port_arbiter;

  localparam int AW = 13;
  localparam int DW = 64;
  localparam int NB = 8;

  typedef struct {
    logic          wv, wcen, wwen;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [NB-1:0] wbe;
    logic          rv, rcen, rwen;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;
    logic [NB-1:0] rbe;
  } req_t;

  typedef struct {
    logic          gw, gr, cen, wen;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [NB-1:0] be;
    int            cyc;
  } gexp_t;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } rexp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          wr_valid, wr_cen, wr_wen, rd_valid, rd_cen, rd_wen;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_wdata, rd_wdata;
  logic [NB-1:0] wr_be, rd_be;

  logic          a_wg, a_rg, a_rvalid, a_cen, a_wen;
  logic [DW-1:0] a_rdata, a_d, a_q;
  logic [AW-1:0] a_a;
  logic [NB-1:0] a_be;
  logic          b_wg, b_rg, b_rvalid, b_cen, b_wen;
  logic [DW-1:0] b_rdata, b_d;
  logic [AW-1:0] b_a;
  logic [NB-1:0] b_be;
  logic [DW-1:0] b_q = 64'h0123_4567_89AB_CDEF;

  axi_mem_port_arbiter u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .wr_valid_i(wr_valid), .wr_grant_o(a_wg), .wr_cen_i(wr_cen), .wr_wen_i(wr_wen),
    .wr_addr_i(wr_addr), .wr_wdata_i(wr_wdata), .wr_be_i(wr_be),
    .rd_valid_i(rd_valid), .rd_grant_o(a_rg), .rd_cen_i(rd_cen), .rd_wen_i(rd_wen),
    .rd_addr_i(rd_addr), .rd_wdata_i(rd_wdata), .rd_be_i(rd_be),
    .rd_rvalid_o(a_rvalid), .rd_rdata_o(a_rdata),
    .MEM_CEN_o(a_cen), .MEM_WEN_o(a_wen), .MEM_A_o(a_a), .MEM_D_o(a_d),
    .MEM_BE_o(a_be), .MEM_Q_i(a_q)
  );

  axi_mem_port_arbiter #(.WR_WEIGHT(3), .RD_WEIGHT(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .wr_valid_i(wr_valid), .wr_grant_o(b_wg), .wr_cen_i(wr_cen), .wr_wen_i(wr_wen),
    .wr_addr_i(wr_addr), .wr_wdata_i(wr_wdata), .wr_be_i(wr_be),
    .rd_valid_i(rd_valid), .rd_grant_o(b_rg), .rd_cen_i(rd_cen), .rd_wen_i(rd_wen),
    .rd_addr_i(rd_addr), .rd_wdata_i(rd_wdata), .rd_be_i(rd_be),
    .rd_rvalid_o(b_rvalid), .rd_rdata_o(b_rdata),
    .MEM_CEN_o(b_cen), .MEM_WEN_o(b_wen), .MEM_A_o(b_a), .MEM_D_o(b_d),
    .MEM_BE_o(b_be), .MEM_Q_i(b_q)
  );

  // SRAM behind instance A: one-cycle read latency, byte-masked writes.
  logic [DW-1:0] sram    [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  function automatic logic [DW-1:0] be_merge(input logic [DW-1:0] old_v,
                                             input logic [DW-1:0] new_v,
                                             input logic [NB-1:0] be);
    logic [DW-1:0] r;
    r = old_v;
    for (int b = 0; b < NB; b++) if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (!a_cen) begin
      if (!a_wen) sram[a_a] <= be_merge(sram[a_a], a_d, a_be);
      else        a_q <= sram[a_a];
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int k [2];
  gexp_t gq [2][$];
  rexp_t rq [2][$];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  // Contested grants follow a fixed repeating pattern: RD_W reads then WR_W writes.
  task automatic model_cycle(input int i, input req_t r);
    int    rdw, wrw, p;
    gexp_t e;
    rexp_t x;
    logic  cen_g, wen_g;
    logic [AW-1:0] a_g;
    rdw = (i == 0) ? 4 : 1;
    wrw = (i == 0) ? 4 : 3;
    if (r.wv && r.rv) begin
      p    = k[i] % (rdw + wrw);
      e.gr = (p < rdw);
      e.gw = !e.gr;
      k[i]++;
    end else begin
      e.gw = r.wv;
      e.gr = r.rv;
    end
    e.cen = 1'b1; e.wen = 1'b1; e.a = r.raddr; e.d = r.rdata; e.be = r.rbe;
    if (e.gw) begin
      e.cen = r.wcen; e.wen = r.wwen; e.a = r.waddr; e.d = r.wdata; e.be = r.wbe;
    end else if (e.gr) begin
      e.cen = r.rcen; e.wen = r.rwen;
    end
    e.cyc = cyc;
    gq[i].push_back(e);
    cen_g = e.cen; wen_g = e.wen; a_g = e.a;
    if (i == 0 && !cen_g && !wen_g) ref_mem[a_g] = be_merge(ref_mem[a_g], e.d, e.be);
    if (e.gr && !r.rcen && r.rwen) begin
      x.data = (i == 0) ? ref_mem[a_g] : b_q;
      x.due  = cyc + 1;
      rq[i].push_back(x);
    end
  endtask

  task automatic drive(input req_t r);
    @(posedge clk);
    #1;
    cyc++;
    wr_valid = r.wv; wr_cen = r.wcen; wr_wen = r.wwen;
    wr_addr = r.waddr; wr_wdata = r.wdata; wr_be = r.wbe;
    rd_valid = r.rv; rd_cen = r.rcen; rd_wen = r.rwen;
    rd_addr = r.raddr; rd_wdata = r.rdata; rd_be = r.rbe;
    model_cycle(0, r);
    model_cycle(1, r);
  endtask

  task automatic mon(input int i, input logic gw, input logic gr, input logic cen,
                     input logic wen, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic [NB-1:0] be, input logic rv, input logic [DW-1:0] rdata);
    gexp_t e;
    rexp_t x;
    string s;
    s = (i == 0) ? "A." : "B.";
    chk({s, "double_grant"}, gw & gr, 0);
    if (gq[i].size() > 0 && gq[i][0].cyc == cyc) begin
      e = gq[i].pop_front();
      chk({s, "wr_grant"}, gw, e.gw);
      chk({s, "rd_grant"}, gr, e.gr);
      chk({s, "mem_cen"}, cen, e.cen);
      chk({s, "mem_wen"}, wen, e.wen);
      chk({s, "mem_a"}, a, e.a);
      chk({s, "mem_d"}, d, e.d);
      chk({s, "mem_be"}, be, e.be);
    end
    if (rv) begin
      if (rq[i].size() == 0) begin
        chk({s, "rvalid_spurious"}, rv, 0);
      end else begin
        x = rq[i].pop_front();
        chk({s, "rvalid_cycle"}, cyc, x.due);
        chk({s, "rdata"}, rdata, x.data);
      end
    end
    while (rq[i].size() > 0 && rq[i][0].due <= cyc) begin
      chk({s, "rvalid_missing"}, rv, 1);
      void'(rq[i].pop_front());
    end
  endtask

  always @(negedge clk) begin
    mon(0, a_wg, a_rg, a_cen, a_wen, a_a, a_d, a_be, a_rvalid, a_rdata);
    mon(1, b_wg, b_rg, b_cen, b_wen, b_a, b_d, b_be, b_rvalid, b_rdata);
  end

  function automatic req_t idle_req();
    req_t r;
    r.wv = 0; r.wcen = 1; r.wwen = 1; r.waddr = '0; r.wdata = '0; r.wbe = '0;
    r.rv = 0; r.rcen = 1; r.rwen = 1; r.raddr = '0; r.rdata = '0; r.rbe = '0;
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.wv    = ($urandom_range(0, 3) != 0);
    r.wcen  = ($urandom_range(0, 15) == 0);
    r.wwen  = ($urandom_range(0, 15) == 0);
    r.waddr = AW'($urandom_range(0, 31));
    r.wdata = {$urandom, $urandom};
    r.wbe   = NB'($urandom);
    r.rv    = ($urandom_range(0, 3) != 0);
    r.rcen  = ($urandom_range(0, 15) == 0);
    r.rwen  = ($urandom_range(0, 15) != 0);
    r.raddr = AW'($urandom_range(0, 31));
    r.rdata = {$urandom, $urandom};
    r.rbe   = NB'($urandom);
    return r;
  endfunction

  function automatic req_t contend_req(input logic [AW-1:0] wa, input logic [AW-1:0] ra);
    req_t r;
    r = idle_req();
    r.wv = 1; r.wcen = 0; r.wwen = 0; r.waddr = wa; r.wdata = {32'h5A5A_0000, 19'd0, wa}; r.wbe = '1;
    r.rv = 1; r.rcen = 0; r.rwen = 1; r.raddr = ra;
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    req_t r;
    for (int i = 0; i < (1 << AW); i++) begin
      sram[i] = '0;
      ref_mem[i] = '0;
    end
    a_q = '0;
    k[0] = 0; k[1] = 0;
    r = idle_req();
    wr_valid = 0; wr_cen = 1; wr_wen = 1; wr_addr = '0; wr_wdata = '0; wr_be = '0;
    rd_valid = 0; rd_cen = 1; rd_wen = 1; rd_addr = '0; rd_wdata = '0; rd_be = '0;
    #2;
    chk("reset_wr_grant", a_wg, 0);
    chk("reset_rd_grant", a_rg, 0);
    chk("reset_mem_cen", a_cen, 1);
    chk("reset_mem_wen", a_wen, 1);
    chk("reset_rvalid", a_rvalid, 0);
    chk("reset_rvalid_b", b_rvalid, 0);
    drive(r);
    drive(r);
    rst_n = 1'b1;

    // Continuous contention from reset
    for (int i = 0; i < 12; i++) drive(contend_req(AW'(i + 32), AW'(i)));
    drive(idle_req());

    for (int i = 0; i < 10; i++) begin
      r = idle_req();
      r.wv = 1; r.wcen = 0; r.wwen = 0; r.waddr = AW'(i);
      r.wdata = {$urandom, $urandom}; r.wbe = '1;
      drive(r);
    end

    r = idle_req();
    r.wv = 1; r.wcen = 0; r.wwen = 0; r.waddr = 13'h10;
    r.wdata = 64'hDEADBEEF_CAFEF00D; r.wbe = '1;
    drive(r);
    r = idle_req();
    r.rv = 1; r.rcen = 0; r.rwen = 1; r.raddr = 13'h10;
    drive(r);
    drive(idle_req());
    drive(idle_req());

    // Mid-operation reset with a read in flight
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    k[0] = 0; k[1] = 0;
    drive(contend_req(13'h40, 13'h10));
    drive(contend_req(13'h41, 13'h10));
    @(posedge clk);
    #1;
    cyc++;
    chk("inflight_rvalid", a_rvalid, 1);
    rst_n = 1'b0;
    wr_valid = 0; rd_valid = 0;
    #1;
    chk("reset_clears_rvalid_a", a_rvalid, 0);
    chk("reset_clears_rvalid_b", b_rvalid, 0);
    gq[0].delete(); gq[1].delete(); rq[0].delete(); rq[1].delete();
    k[0] = 0; k[1] = 0;
    drive(idle_req());
    drive(idle_req());
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) drive(contend_req(AW'(i + 64), 13'h10));

    for (int i = 0; i < 3000; i++) drive(rand_req());
    drive(idle_req());
    drive(idle_req());
    @(posedge clk);
    #1;
    chk("queues_drained", gq[0].size() + gq[1].size() + rq[0].size() + rq[1].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_mem_port_arbiter.md
# axi_mem_port_arbiter

Arbitrates the AXI write-only and read-only memory controllers onto one single-port SRAM inside the AXI memory interface. It sits directly downstream of the write controller: it consumes that controller's `valid_o`/MEM_* request and returns its `grant_i`. The read controller is served the same way. Contested cycles are resolved by weighted round-robin, so a long burst on one side cannot starve the other. Read data is returned with a registered valid one cycle after the read access.

## Interface
- `MEM_ADDR_WIDTH`, 13, SRAM word-address width
- `DATA_WIDTH`, 64, SRAM data width
- `NUMBYTES`, DATA_WIDTH/8, byte-enable width
- `WR_WEIGHT`, 4, consecutive contested grants the write side may take before yielding (≥1)
- `RD_WEIGHT`, 4, consecutive contested grants the read side may take before yielding (≥1)

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `wr_valid_i`  in  1  write controller requests an access this cycle
- `wr_grant_o`  out  1  write access performed at this edge
- `wr_cen_i`, `wr_wen_i`  in  1 each  write-side chip enable / write enable, both active low
- `wr_addr_i`  in  MEM_ADDR_WIDTH  write word address
- `wr_wdata_i`  in  DATA_WIDTH  write data
- `wr_be_i`  in  NUMBYTES  write byte enables
- `rd_valid_i`, `rd_grant_o`, `rd_cen_i`, `rd_wen_i`, `rd_addr_i`, `rd_wdata_i`, `rd_be_i`  same as the write side, for the read controller
- `rd_rvalid_o`  out  1  `rd_rdata_o` is valid
- `rd_rdata_o`  out  DATA_WIDTH  read data
- `MEM_CEN_o`  out  1  SRAM chip enable, active low
- `MEM_WEN_o`  out  1  SRAM write enable, active low
- `MEM_A_o`  out  MEM_ADDR_WIDTH  SRAM address
- `MEM_D_o`  out  DATA_WIDTH  SRAM write data
- `MEM_BE_o`  out  NUMBYTES  SRAM byte enables
- `MEM_Q_i`  in  DATA_WIDTH  SRAM read data, one-cycle latency

## Operation
State:
- `owner` ∈ {OWN_RD, OWN_WR}; reset value OWN_RD.
- `cnt`, sized $clog2(max(WR_WEIGHT, RD_WEIGHT))+1; reset value 0.
- `rd_rvalid_o` register; reset value 0.

Per-cycle grant rule (grants are combinational from the valids and state):
- Neither side valid: no grant; `owner` and `cnt` hold.
- Exactly one side valid: grant that side; `owner` and `cnt` hold. Uncontested cycles neither consume nor reset the weight.
- Both sides valid (contested): grant `owner`.
  - If `cnt+1 == weight(owner)`: `owner` ← other side, `cnt` ← 0.
  - Otherwise: `cnt` ← `cnt+1`.

Memory mux:
- Granted side drives `MEM_A_o`, `MEM_D_o`, `MEM_BE_o` and `MEM_WEN_o`. `MEM_CEN_o` is the granted side's cen.
- No grant: `MEM_CEN_o` = 1, `MEM_WEN_o` = 1, and A/D/BE are taken from the read side (deterministic, no X).

Read return:
- `rd_rvalid_o` ← `rd_grant_o & ~rd_cen_i & rd_wen_i`.
- `rd_rdata_o` = `MEM_Q_i` (combinational passthrough).
- Write grants never raise `rd_rvalid_o`.

Elaboration checks: WR_WEIGHT = 0 or RD_WEIGHT = 0 is a fatal error.

## Timing
- Grant is produced in the same cycle as its valid. The SRAM access occurs at the next rising edge.
- No combinational path from `*_grant_o` back into `*_valid_i` is allowed; both controllers derive valid from their own inputs.
- `rd_rvalid_o` rises exactly 1 cycle after a granted read and stays high for 1 cycle per read. Back-to-back reads give a continuous `rd_rvalid_o`.
- At most one grant per cycle; `wr_grant_o & rd_grant_o` is never 1.
- Reset mid-operation: `owner`, `cnt` and `rd_rvalid_o` clear asynchronously. An in-flight read's data is dropped.
- Weight 1 on both sides gives strict alternation under continuous contention.

## Structure
- Shared package `axi_mem_if_pkg`: `owner_t` enum (OWN_RD, OWN_WR).
- Sub-module `axi_mem_wrr_core`: 2-input weighted round-robin with the `owner`/`cnt` state, grant outputs, and no datapath.
- Top level: the core, the memory mux, and the `rd_rvalid_o` register.

## Test plan
- Reset with valids low → all grants 0, `MEM_CEN_o`=1, `MEM_WEN_o`=1, `rd_rvalid_o`=0.
- `wr_valid_i` only, 10 cycles, addresses 0x00–0x09 → `wr_grant_o`=1 every cycle, `MEM_WEN_o`=0, `MEM_A_o` follows; `rd_rvalid_o` stays 0.
- Write 0xDEADBEEF_CAFEF00D to 0x10, then read 0x10 → `rd_rvalid_o`=1 one cycle after the read grant, `rd_rdata_o`=0xDEADBEEF_CAFEF00D.
- Both valid continuously from reset, weights 4/4 → RD granted cycles 0–3, WR 4–7, RD 8–11; never a double grant.
- RD_WEIGHT=1, WR_WEIGHT=3, continuous contention → grant pattern R,W,W,W,R,W,W,W. An inserted write-only cycle after the first W leaves the next two contested cycles as W,W.
- Contended, assert `rst_n` low after 2 RD grants with a read in flight → `rd_rvalid_o` clears immediately; after release, 4 RD grants precede the first WR grant.
